// File: rtl/ifetch_unit.sv
// Instruction fetch engine: reads opcode at PC and, when IR[ARG_BIT] is set, the operand at PC+1
// over a shared RAM port, then presents IR/ARG with a one-cycle fetch_valid pulse.
module ifetch_unit #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int ARG_BIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  input  logic          fetch_req,
  output logic          fetch_ready,
  input  logic          flush,
  output logic          fetch_valid,
  output logic [DW-1:0] IR,
  output logic [DW-1:0] ARG,
  output logic          has_arg,
  output logic          pc_inc,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_OP_REQ   = 3'd1;
  localparam logic [2:0] S_OP_WAIT  = 3'd2;
  localparam logic [2:0] S_ARG_REQ  = 3'd3;
  localparam logic [2:0] S_ARG_WAIT = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] arg_q, arg_d;
  logic          has_arg_q, has_arg_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    arg_d     = arg_q;
    has_arg_d = has_arg_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_req) begin
          addr_d    = pc;
          has_arg_d = 1'b0;
          arg_d     = '0;
          state_d   = S_OP_REQ;
        end
      end
      S_OP_REQ: begin
        if (mem_gnt) state_d = S_OP_WAIT;
      end
      S_OP_WAIT: begin
        ir_d = mem_rdata;
        if (mem_rdata[ARG_BIT]) begin
          has_arg_d = 1'b1;
          addr_d    = addr_q + 1'b1;
          state_d   = S_ARG_REQ;
        end else begin
          state_d = S_DONE;
        end
      end
      S_ARG_REQ: begin
        if (mem_gnt) state_d = S_ARG_WAIT;
      end
      S_ARG_WAIT: begin
        arg_d   = mem_rdata;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A flush discards anything sampled this cycle; IR/ARG keep their last values.
    if (flush) begin
      state_d   = S_IDLE;
      addr_d    = addr_q;
      ir_d      = ir_q;
      arg_d     = arg_q;
      has_arg_d = has_arg_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      ir_q      <= '0;
      arg_q     <= '0;
      has_arg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      arg_q     <= arg_d;
      has_arg_q <= has_arg_d;
    end
  end

  // Strobes are decoded from state; flush masks them in the cycle it is raised.
  assign fetch_ready = (state_q == S_IDLE);
  assign mem_rd      = (state_q == S_OP_REQ) || (state_q == S_ARG_REQ);
  assign mem_addr    = addr_q;
  assign pc_inc      = ((state_q == S_OP_WAIT) || (state_q == S_ARG_WAIT)) && !flush;
  assign fetch_valid = (state_q == S_DONE) && !flush;
  assign IR          = ir_q;
  assign ARG         = arg_q;
  assign has_arg     = has_arg_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: RAM model with one-cycle read latency and a controllable grant.
module tb_ifetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pc;
  logic       fetch_req;
  logic       fetch_ready;
  logic       flush;
  logic       fetch_valid;
  logic [7:0] IR;
  logic [7:0] ARG;
  logic       has_arg;
  logic       pc_inc;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic       mem_gnt;
  logic [7:0] mem_rdata = 8'h00;
  logic       gnt_on;

  logic [7:0] mem [256];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mem_gnt = gnt_on;

  always @(posedge clk) if (mem_rd && mem_gnt) mem_rdata <= mem[mem_addr];

  ifetch_unit #(.AW(8), .DW(8), .ARG_BIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_req(fetch_req), .fetch_ready(fetch_ready),
    .flush(flush), .fetch_valid(fetch_valid), .IR(IR), .ARG(ARG), .has_arg(has_arg),
    .pc_inc(pc_inc), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one fetch; withholds grant for 'stall' cycles once the operand request is up.
  task automatic run_fetch(input logic [7:0] p, input int stall, output int lat,
                           output int incs, output logic [7:0] ra0, output logic [7:0] ra1);
    int nrd;
    lat = -1; incs = 0; nrd = 0; ra0 = 8'h00; ra1 = 8'h00;
    @(negedge clk);
    pc = p; fetch_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      fetch_req = 1'b0;
      gnt_on    = 1'b1;
      if (mem_rd && incs == 1 && stall > 0) begin
        gnt_on = 1'b0;
        stall--;
        check("stall_rd", mem_rd, 1);
        check("stall_addr", mem_addr, p + 8'd1);
      end
      #1;
      if (pc_inc) incs++;
      if (mem_rd && gnt_on) begin
        if (nrd == 0) ra0 = mem_addr; else ra1 = mem_addr;
        nrd++;
      end
      if (fetch_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat, incs, vcnt;
    logic [7:0] a0, a1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; pc = 8'h00; fetch_req = 1'b0; flush = 1'b0; gnt_on = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", fetch_ready, 1);
    check("rst_valid", fetch_valid, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_pc_inc", pc_inc, 0);
    check("rst_ir", IR, 0);
    check("rst_addr", mem_addr, 0);
    rst_n = 1'b1;

    // 1-byte instruction
    mem[8'h20] = 8'h01;
    run_fetch(8'h20, 0, lat, incs, a0, a1);
    check("t1_lat", lat, 3);
    check("t1_incs", incs, 1);
    check("t1_addr", a0, 8'h20);
    check("t1_ir", IR, 8'h01);
    check("t1_has_arg", has_arg, 0);
    check("t1_arg", ARG, 8'h00);

    // 2-byte instruction
    mem[8'h20] = 8'h08; mem[8'h21] = 8'h35;
    run_fetch(8'h20, 0, lat, incs, a0, a1);
    check("t2_lat", lat, 5);
    check("t2_incs", incs, 2);
    check("t2_addr0", a0, 8'h20);
    check("t2_addr1", a1, 8'h21);
    check("t2_ir", IR, 8'h08);
    check("t2_arg", ARG, 8'h35);
    check("t2_has_arg", has_arg, 1);

    // grant withheld for 3 cycles on the operand read
    run_fetch(8'h20, 3, lat, incs, a0, a1);
    check("t3_lat", lat, 8);
    check("t3_incs", incs, 2);
    check("t3_arg", ARG, 8'h35);

    // operand address wraps FF -> 00
    mem[8'hFF] = 8'h0C; mem[8'h00] = 8'h7A;
    run_fetch(8'hFF, 0, lat, incs, a0, a1);
    check("t4_lat", lat, 5);
    check("t4_addr0", a0, 8'hFF);
    check("t4_addr1", a1, 8'h00);
    check("t4_arg", ARG, 8'h7A);
    repeat (2) @(negedge clk);
    check("t4_ir_hold", IR, 8'h0C);
    check("t4_valid_once", fetch_valid, 0);

    // flush in ARG_WAIT
    incs = 0; vcnt = 0;
    @(negedge clk); pc = 8'h20; fetch_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); fetch_req = 1'b0; #1;
      if (pc_inc) incs++;
      if (fetch_valid) vcnt++;
    end
    @(negedge clk); flush = 1'b1; #1;
    check("t5_inc_masked", pc_inc, 0);
    if (pc_inc) incs++;
    if (fetch_valid) vcnt++;
    @(negedge clk); flush = 1'b0; #1;
    check("t5_ready", fetch_ready, 1);
    check("t5_mem_rd", mem_rd, 0);
    for (int c = 0; c < 5; c++) begin
      if (fetch_valid) vcnt++;
      if (pc_inc) incs++;
      @(negedge clk); #1;
    end
    check("t5_incs", incs, 1);
    check("t5_no_valid", vcnt, 0);
    check("t5_ir_kept", IR, 8'h08);
    check("t5_arg_cleared", ARG, 8'h00);

    // flush and request together in IDLE
    @(negedge clk); pc = 8'h20; fetch_req = 1'b1; flush = 1'b1;
    @(negedge clk); fetch_req = 1'b0; flush = 1'b0; #1;
    check("t5_fr_ready", fetch_ready, 1);
    check("t5_fr_mem_rd", mem_rd, 0);

    // async reset in OP_WAIT
    @(negedge clk); pc = 8'h20; fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0;
    @(negedge clk); #1;
    check("t6_in_op_wait", pc_inc, 1);
    rst_n = 1'b0; #1;
    check("t6_pc_inc", pc_inc, 0);
    check("t6_mem_rd", mem_rd, 0);
    check("t6_ir", IR, 0);
    check("t6_arg", ARG, 0);
    check("t6_has_arg", has_arg, 0);
    check("t6_addr", mem_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    mem[8'h20] = 8'h01;
    run_fetch(8'h20, 0, lat, incs, a0, a1);
    check("t6_lat", lat, 3);
    check("t6_ir_after", IR, 8'h01);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
